// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared opcodes, FSM state/class enums and datapath select encodings
// for the multi-cycle RV32I sequencer.
package rv_ctrl_pkg;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
    typedef enum logic [2:0] {C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR} cls_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_RF  = 2'b10;
    localparam logic [1:0] ALU_IF  = 2'b11;

    localparam logic [1:0] PC_4   = 2'b00;
    localparam logic [1:0] PC_REL = 2'b01;
    localparam logic [1:0] PC_RS1 = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;
endpackage

// File: rtl/ctrl_opdecode.sv
// ctrl_opdecode: combinational opcode to instruction class, flagging unsupported opcodes.
module ctrl_opdecode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] cls,
    output logic       illegal
);
    always_comb begin
        cls = C_R;
        illegal = 1'b0;
        case (opcode)
            OP_R:     cls = C_R;
            OP_I:     cls = C_I;
            OP_LOAD:  cls = C_LOAD;
            OP_STORE: cls = C_STORE;
            OP_BR:    cls = C_BR;
            OP_JAL:   cls = C_JAL;
            OP_JALR:  cls = C_JALR;
            default:  illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/exec/mem/writeback sequencer for the RV32I datapath,
// sharing one handshaked memory port and counting retired instructions.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic [1:0]       alu_op,
    output logic             alu_src_b,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             halted
);
    state_e           state_q, state_d;
    cls_e             cls_q, cls_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [2:0]       dec_cls;
    logic             dec_illegal;
    logic             exec, fetch_done, link;

    ctrl_opdecode u_dec (
        .opcode  (opcode),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d = state_q;
        cls_d = cls_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                cls_d = cls_e'(dec_cls);
                state_d = dec_illegal ? S_HALT : S_EXEC;
            end
            S_EXEC:   state_d = cls_q == C_BR ? S_FETCH
                              : (cls_q == C_LOAD || cls_q == C_STORE) ? S_MEM : S_WB;
            S_MEM:    state_d = !mem_ready ? S_MEM : cls_q == C_STORE ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
        retire = state_d == S_FETCH && state_q inside {S_EXEC, S_MEM, S_WB};
        instret_d = instret_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cls_q <= C_R;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q <= cls_d;
            instret_q <= instret_d;
        end
    end

    assign exec = state_q == S_EXEC;
    assign fetch_done = state_q == S_FETCH && mem_ready;
    assign link = cls_q inside {C_JAL, C_JALR};

    always_comb begin
        mem_req = state_q inside {S_FETCH, S_MEM};
        mem_we = state_q == S_MEM && cls_q == C_STORE;
        addr_sel = state_q == S_MEM;
        ir_write = fetch_done;
        pc_write = fetch_done || (exec && (cls_q == C_BR ? branch_taken : link));
        pc_sel = !exec ? PC_4 : cls_q == C_JALR ? PC_RS1
               : cls_q inside {C_BR, C_JAL} ? PC_REL : PC_4;
        alu_op = !exec ? ALU_ADD : cls_q == C_R ? ALU_RF : cls_q == C_I ? ALU_IF
               : cls_q == C_BR ? ALU_BR : ALU_ADD;
        alu_src_b = exec && !(cls_q inside {C_R, C_BR});
        reg_write = state_q == S_WB;
        wb_sel = state_q != S_WB ? WB_ALU : cls_q == C_LOAD ? WB_MEM : link ? WB_LINK : WB_ALU;
        halted = state_q == S_HALT;
    end

    assign instret = instret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized scenarios checked cycle by cycle against a per-instruction
// expected-output script built from the instruction class rules.
module tb_multicycle_ctrl;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_BR = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

    typedef struct packed {
        logic mreq, we, asel, irw, pcw;
        logic [1:0] psel, aop;
        logic asb, rw;
        logic [1:0] wbs;
        logic ret, hlt;
    } ov_t;
    typedef struct packed {
        logic rdy;
        ov_t  e;
    } cyc_t;

    logic clk = 1'b0, rstn = 1'b0;
    logic [6:0] opcode = '0;
    logic branch_taken = 1'b0, mem_ready = 1'b0;
    logic mem_req, mem_we, addr_sel, ir_write, pc_write, alu_src_b, reg_write, retire, halted;
    logic [1:0] pc_sel, alu_op, wb_sel;
    logic [31:0] instret;
    logic w_mem_req, w_mem_we, w_addr_sel, w_ir_write, w_pc_write, w_alu_src_b;
    logic w_reg_write, w_retire, w_halted;
    logic [1:0] w_pc_sel, w_alu_op, w_wb_sel, w_instret;
    ov_t act, w_act;
    int errors = 0, checks = 0, model_cnt = 0;
    logic [6:0] legal_ops [7] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR};

    always #5 clk = ~clk;

    multicycle_ctrl u_dut (
        .clk(clk), .rstn(rstn), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel), .alu_op(alu_op),
        .alu_src_b(alu_src_b), .reg_write(reg_write), .wb_sel(wb_sel), .retire(retire),
        .instret(instret), .halted(halted)
    );

    multicycle_ctrl #(.CNT_W(2)) u_wrap (
        .clk(clk), .rstn(rstn), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(w_mem_req), .mem_we(w_mem_we), .addr_sel(w_addr_sel),
        .ir_write(w_ir_write), .pc_write(w_pc_write), .pc_sel(w_pc_sel), .alu_op(w_alu_op),
        .alu_src_b(w_alu_src_b), .reg_write(w_reg_write), .wb_sel(w_wb_sel), .retire(w_retire),
        .instret(w_instret), .halted(w_halted)
    );

    assign act = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_sel, alu_op,
                  alu_src_b, reg_write, wb_sel, retire, halted};
    assign w_act = {w_mem_req, w_mem_we, w_addr_sel, w_ir_write, w_pc_write, w_pc_sel, w_alu_op,
                    w_alu_src_b, w_reg_write, w_wb_sel, w_retire, w_halted};

    // Builds the expected output script of one instruction from its class, then drives it;
    // the run must start at the beginning of a FETCH cycle.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                             input logic taken, input string tag);
        cyc_t q[$];
        ov_t e;
        logic r, i, ld, st, br, jal, jalr;
        r = op == OP_R; i = op == OP_I; ld = op == OP_LOAD; st = op == OP_STORE;
        br = op == OP_BR; jal = op == OP_JAL; jalr = op == OP_JALR;
        e = '0; e.mreq = 1'b1;
        for (int k = 0; k < fw; k++) q.push_back({1'b0, e});
        e.irw = 1'b1; e.pcw = 1'b1;
        q.push_back({1'b1, e});
        q.push_back({1'($urandom), ov_t'('0)});
        if (r | i | ld | st | br | jal | jalr) begin
            e = '0;
            e.pcw = br ? taken : (jal | jalr);
            e.psel = (br | jal) ? 2'b01 : jalr ? 2'b10 : 2'b00;
            e.aop = r ? 2'b10 : i ? 2'b11 : br ? 2'b01 : 2'b00;
            e.asb = !(r | br);
            e.ret = br;
            q.push_back({1'($urandom), e});
            if (ld | st) begin
                e = '0; e.mreq = 1'b1; e.we = st; e.asel = 1'b1;
                for (int k = 0; k < mw; k++) q.push_back({1'b0, e});
                e.ret = st;
                q.push_back({1'b1, e});
            end
            if (!(br | st)) begin
                e = '0; e.rw = 1'b1; e.ret = 1'b1;
                e.wbs = ld ? 2'b01 : (jal | jalr) ? 2'b10 : 2'b00;
                q.push_back({1'($urandom), e});
            end
        end
        foreach (q[k]) begin
            #1;
            mem_ready = q[k].rdy;
            opcode = k > fw ? op : 7'($urandom);
            branch_taken = k == fw + 2 ? taken : 1'($urandom);
            #1;
            checks++;
            if (act !== q[k].e) begin
                errors++;
                $display("FAIL %s cycle %0d outputs: got %h expected %h", tag, k, act, q[k].e);
            end
            checks++;
            if (w_act !== q[k].e) begin
                errors++;
                $display("FAIL %s cycle %0d narrow outputs: got %h expected %h", tag, k, w_act, q[k].e);
            end
            checks++;
            if (instret !== model_cnt[31:0] || w_instret !== model_cnt[1:0]) begin
                errors++;
                $display("FAIL %s cycle %0d instret: got %0d/%0d expected %0d/%0d",
                         tag, k, instret, w_instret, model_cnt[31:0], model_cnt[1:0]);
            end
            @(posedge clk);
            if (q[k].e.ret) model_cnt++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (act !== '0 || instret !== '0) begin
            errors++;
            $display("FAIL reset_hold: got %h/%0d expected 0/0", act, instret);
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL reset_idle: got %h expected 0", act);
        end
        @(posedge clk);
    endtask

    task automatic test_rtype;
        run_instr(OP_R, 0, 0, 1'b0, "rtype");
    endtask

    task automatic test_load_wait;
        run_instr(OP_LOAD, 0, 3, 1'b0, "load_wait");
    endtask

    task automatic test_store_branch;
        run_instr(OP_STORE, 0, 0, 1'b0, "store");
        run_instr(OP_BR, 0, 0, 1'b0, "br_not_taken");
        run_instr(OP_BR, 0, 0, 1'b1, "br_taken");
    endtask

    task automatic test_jalr;
        run_instr(OP_JALR, 1, 0, 1'b0, "jalr");
        run_instr(OP_JAL, 0, 0, 1'b0, "jal");
        run_instr(OP_I, 2, 0, 1'b0, "itype");
    endtask

    task automatic test_random;
        for (int n = 0; n < 25; n++)
            run_instr(legal_ops[$urandom_range(0, 6)], $urandom_range(0, 2),
                      $urandom_range(0, 3), 1'($urandom), "random");
    endtask

    task automatic test_wrap;
        while (model_cnt[1:0] != 2'd3) run_instr(OP_R, 0, 0, 1'b0, "wrap_fill");
        run_instr(OP_BR, 0, 0, 1'b1, "wrap_last");
        #1;
        checks++;
        if (w_instret !== 2'd0 || instret !== model_cnt[31:0]) begin
            errors++;
            $display("FAIL wrap: got %0d/%0d expected 0/%0d", w_instret, instret, model_cnt);
        end
    endtask

    task automatic test_reset_mid;
        int cyc = 0;
        #1 mem_ready = 1'b1;
        @(posedge clk);
        #1 opcode = OP_LOAD; mem_ready = 1'b0;
        while (!addr_sel && cyc < 10) begin
            @(posedge clk);
            #1 cyc++;
        end
        checks++;
        if (!(mem_req && addr_sel)) begin
            errors++;
            $display("FAIL reset_mid_mem: got mem_req=%b addr_sel=%b expected 1/1", mem_req, addr_sel);
        end
        #1 rstn = 1'b0;
        #1;
        model_cnt = 0;
        checks++;
        if (act !== '0 || w_act !== '0 || instret !== '0 || w_instret !== '0) begin
            errors++;
            $display("FAIL reset_mid_drop: got %h/%0d expected 0/0", act, instret);
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL reset_mid_idle: got %h expected 0", act);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1 || addr_sel !== 1'b0 || instret !== '0) begin
            errors++;
            $display("FAIL reset_mid_fetch: got mem_req=%b addr_sel=%b instret=%0d expected 1/0/0",
                     mem_req, addr_sel, instret);
        end
    endtask

    task automatic test_illegal;
        ov_t h;
        h = '0; h.hlt = 1'b1;
        run_instr(OP_R, 0, 0, 1'b0, "pre_illegal");
        run_instr(7'b0000000, 0, 0, 1'b0, "illegal");
        for (int k = 0; k < 6; k++) begin
            #1;
            mem_ready = 1'($urandom);
            branch_taken = 1'($urandom);
            opcode = legal_ops[$urandom_range(0, 6)];
            #1;
            checks++;
            if (act !== h || instret !== model_cnt[31:0]) begin
                errors++;
                $display("FAIL halt cycle %0d: got %h/%0d expected %h/%0d", k, act, instret, h, model_cnt);
            end
            @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_store_branch();
        test_jalr();
        test_random();
        test_wrap();
        test_reset_mid();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
